riscv_regfile: RTL and testbench



---
 rtl/riscv_configs.sv | 11 +
 rtl/riscv_register.sv | 25 ++
 rtl/riscv_regfile.sv | 70 +++++++
 tb/tb_riscv_regfile.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/riscv_configs.sv
// Shared RISC-V core configuration: datapath width and register-file geometry.
package riscv_configs;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = REG_ADDR_W'(2);

endpackage

// File: rtl/riscv_register.sv
// Enabled storage register with asynchronous active-low reset to a fixed value.
module riscv_register #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            q_reg <= INIT;
        end else if (i_en) begin
            q_reg <= i_d;
        end
    end

    assign o_q = q_reg;

endmodule

// File: rtl/riscv_regfile.sv
// Integer register file: x1..x31 storage cells, x0 hardwired to zero,
// two combinational read ports with optional same-cycle write forwarding.
module riscv_regfile
    import riscv_configs::*;
#(
    parameter logic [XLEN-1:0] REGISTER_INIT = '0,
    parameter logic [XLEN-1:0] SP_INIT       = '0,
    parameter bit              BYPASS        = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_rd_wen,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [XLEN-1:0]       i_rd_data,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data
);

    // Entry 0 is a constant so the read mux needs no special case for x0.
    logic [XLEN-1:0] x_q [NUM_REGS];
    logic [XLEN-1:0] rs1_data_next;
    logic [XLEN-1:0] rs2_data_next;
    logic            fwd_rs1;
    logic            fwd_rs2;

    assign x_q[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_xreg
            localparam logic [XLEN-1:0] INIT_VAL =
                (gi == int'(REG_SP)) ? SP_INIT : REGISTER_INIT;
            logic wen;

            assign wen = i_rd_wen && (i_rd_addr == REG_ADDR_W'(gi));

            riscv_register #(
                .WIDTH (XLEN),
                .INIT  (INIT_VAL)
            ) u_reg (
                .i_clk  (i_clk),
                .i_rstn (i_rstn),
                .i_en   (wen),
                .i_d    (i_rd_data),
                .o_q    (x_q[gi])
            );
        end
    endgenerate

    // Forwarding stays active during reset; only the storage is held.
    assign fwd_rs1 = BYPASS && i_rd_wen && (i_rd_addr == i_rs1_addr) && (i_rs1_addr != REG_ZERO);
    assign fwd_rs2 = BYPASS && i_rd_wen && (i_rd_addr == i_rs2_addr) && (i_rs2_addr != REG_ZERO);

    always_comb begin
        rs1_data_next = x_q[i_rs1_addr];
        rs2_data_next = x_q[i_rs2_addr];
        if (fwd_rs1) begin
            rs1_data_next = i_rd_data;
        end
        if (fwd_rs2) begin
            rs2_data_next = i_rd_data;
        end
    end

    assign o_rs1_data = rs1_data_next;
    assign o_rs2_data = rs2_data_next;

endmodule

// File: tb/tb_riscv_regfile.sv
// Randomized check of riscv_regfile (forwarding and non-forwarding builds)
// against an array model of the architectural register state.
module tb_riscv_regfile;

    localparam logic [31:0] SP_VAL   = 32'h0000_1000;
    localparam logic [31:0] INIT_VAL = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] byp_rs1, byp_rs2;
    logic [31:0] nb_rs1, nb_rs2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    riscv_regfile #(.REGISTER_INIT(INIT_VAL), .SP_INIT(SP_VAL), .BYPASS(1'b1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_rd_wen(rd_wen), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(byp_rs1), .o_rs2_data(byp_rs2)
    );

    riscv_regfile #(.REGISTER_INIT(INIT_VAL), .SP_INIT(SP_VAL), .BYPASS(1'b0)) dut_nb (
        .i_clk(clk), .i_rstn(rstn), .i_rd_wen(rd_wen), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(nb_rs1), .o_rs2_data(nb_rs2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = INIT_VAL;
        model[2] = SP_VAL;
        model[0] = 32'h0;
    endtask

    // Architectural read as seen before the pending write lands.
    function automatic logic [31:0] expect_read(input logic [4:0] a, input bit fwd);
        if (a == 5'd0) return 32'h0;
        if (fwd && rd_wen && rd_addr == a) return rd_data;
        return model[a];
    endfunction

    task automatic check_ports(input string tag);
        check_val({tag, "_byp_rs1"}, byp_rs1, expect_read(rs1_addr, 1'b1));
        check_val({tag, "_byp_rs2"}, byp_rs2, expect_read(rs2_addr, 1'b1));
        check_val({tag, "_nb_rs1"},  nb_rs1,  expect_read(rs1_addr, 1'b0));
        check_val({tag, "_nb_rs2"},  nb_rs2,  expect_read(rs2_addr, 1'b0));
    endtask

    // Drive at negedge, check combinational outputs, then retire through posedge.
    task automatic cycle(input bit wen, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        rd_wen = wen; rd_addr = rd; rd_data = d; rs1_addr = r1; rs2_addr = r2;
        #1;
        check_ports(tag);
        $display("txn %s wen=%0d rd=%0d data=%h rs1=%0d:%h rs2=%0d:%h", tag, wen, rd, d,
                 r1, byp_rs1, r2, byp_rs2);
        @(posedge clk);
        if (rstn && wen && rd != 5'd0) model[rd] = d;
    endtask

    initial begin
        rstn = 1'b0; rd_wen = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Reset values on every index, literal expectations
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_wen = 1'b0; rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            #1;
            check_val($sformatf("rst_rs1_x%0d", i), byp_rs1, (i == 2) ? 32'h1000 : 32'h0);
            check_val($sformatf("rst_rs2_x%0d", 31 - i), nb_rs2, (31 - i == 2) ? 32'h1000 : 32'h0);
        end

        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, "wr_x5");
        cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd_x5");
        check_val("x5_literal", byp_rs1, 32'hDEAD_BEEF);

        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr_x0");
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd_x0");
        check_val("x0_literal", byp_rs1, 32'h0);

        cycle(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0, "wr_x7_old");
        @(negedge clk);
        rd_wen = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234; rs1_addr = 5'd0; rs2_addr = 5'd7;
        #1;
        check_val("bypass_x7_fwd", byp_rs2, 32'h1234);
        check_val("bypass_x7_nofwd", nb_rs2, 32'h0000_0011);
        @(posedge clk);
        model[7] = 32'h1234;
        cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "rd_x7_after");
        check_val("x7_after_edge_nb", nb_rs2, 32'h1234);

        // Reset asserted mid-cycle while a write is pending
        cycle(1'b1, 5'd9, 32'hAAAA, 5'd0, 5'd0, "wr_x9");
        @(negedge clk);
        rd_wen = 1'b1; rd_addr = 5'd9; rd_data = 32'h5555; rs1_addr = 5'd9; rs2_addr = 5'd0;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_val("rst_fwd_x9", byp_rs1, 32'h5555);
        check_val("rst_nb_x9", nb_rs1, INIT_VAL);
        check_val("rst_x0", byp_rs2, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1; rd_wen = 1'b0;
        #1;
        check_val("x9_after_rst", byp_rs1, INIT_VAL);
        check_val("x9_after_rst_nb", nb_rs1, INIT_VAL);
        cycle(1'b1, 5'd9, 32'h7777, 5'd2, 5'd9, "resume_wr");
        cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd2, "resume_rd");

        // Randomized traffic with address collisions encouraged
        for (int n = 0; n < 10000; n++) begin
            logic [4:0]  rd, r1, r2;
            logic [31:0] d;
            bit          wen;
            wen = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 31));
            d   = $urandom();
            r1  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            @(negedge clk);
            rd_wen = wen; rd_addr = rd; rd_data = d; rs1_addr = r1; rs2_addr = r2;
            #1;
            check_ports("rand");
            @(posedge clk);
            if (wen && rd != 5'd0) model[rd] = d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
